// File: rtl/dcache_direct_wb.sv
// dcache_direct_wb: direct-mapped, write-back, write-allocate data cache.
// Serves 32-bit CPU loads/stores from a register line array; on a miss it
// writes back a dirty victim, refills the line from 256-bit memory and
// replays the held request as a hit. Blocking, one request at a time.
// Optional macro DCACHE_PERF_CNT_EN adds perf_hit_cnt/perf_miss_cnt ports.
module dcache_direct_wb #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int LINE_WIDTH     = 256,
  parameter int INDEX_BITS     = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [31:0]               cpu_addr,
  input  logic [3:0]                cpu_be,
  input  logic [31:0]               cpu_wdata,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_ready,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0]     mem_wdata,
  input  logic [LINE_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ready
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]               perf_hit_cnt,
  output logic [31:0]               perf_miss_cnt
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = MEM_ADDR_WIDTH - INDEX_BITS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESP  = 3'd1,
    S_WB    = 3'd2,
    S_RREQ  = 3'd3,
    S_RWAIT = 3'd4
  } state_e;

  state_e                    state_q;
  logic [LINES-1:0]          valid_q;
  logic [LINES-1:0]          dirty_q;
  logic [TAG_BITS-1:0]       tag_q  [LINES];
  logic [LINE_WIDTH-1:0]     data_q [LINES];
  logic                      replay_q;
  logic                      cpu_ready_q;
  logic [31:0]               cpu_rdata_q;
  logic                      mem_req_q;
  logic                      mem_we_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic [LINE_WIDTH-1:0]     mem_wdata_q;

  logic [MEM_ADDR_WIDTH-1:0] line_addr_s;
  logic [INDEX_BITS-1:0]     idx_s;
  logic [TAG_BITS-1:0]       tag_s;
  logic [2:0]                word_sel_s;
  logic [LINE_WIDTH-1:0]     line_s;
  logic [TAG_BITS-1:0]       vic_tag_s;
  logic                      hit_s;
  logic                      vic_dirty_s;
  logic [31:0]               old_word_s;
  logic [31:0]               merged_word_s;
  logic [LINE_WIDTH-1:0]     merged_line_s;
  logic                      unused_s;

  // Address bits outside the line address and word select carry no meaning here.
  assign unused_s = ^{cpu_addr[31:MEM_ADDR_WIDTH+5], cpu_addr[1:0]};

  // Decode the held request against the resident line and build the store-merged line.
  always_comb begin
    line_addr_s   = cpu_addr[MEM_ADDR_WIDTH+4:5];
    idx_s         = line_addr_s[INDEX_BITS-1:0];
    tag_s         = line_addr_s[MEM_ADDR_WIDTH-1:INDEX_BITS];
    word_sel_s    = cpu_addr[4:2];
    line_s        = data_q[idx_s];
    vic_tag_s     = tag_q[idx_s];
    hit_s         = valid_q[idx_s] && (vic_tag_s == tag_s);
    vic_dirty_s   = valid_q[idx_s] && dirty_q[idx_s];
    old_word_s    = line_s[{word_sel_s, 5'b00000} +: 32];
    merged_word_s = old_word_s;
    for (int b = 0; b < 4; b++) begin
      if (cpu_be[b]) begin
        merged_word_s[b*8 +: 8] = cpu_wdata[b*8 +: 8];
      end else begin
        merged_word_s[b*8 +: 8] = old_word_s[b*8 +: 8];
      end
    end
    merged_line_s = line_s;
    merged_line_s[{word_sel_s, 5'b00000} +: 32] = merged_word_s;
  end

  // Tag/data arrays are plain storage: store hits merge, refills install a full line.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cpu_req && hit_s && cpu_we) begin
      data_q[idx_s] <= merged_line_s;
    end else if (state_q == S_RWAIT && mem_ready) begin
      data_q[idx_s] <= mem_rdata;
      tag_q[idx_s]  <= tag_s;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hit_q;
  logic [31:0] perf_miss_q;
`endif

  // Cache controller: state, valid/dirty bits and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      replay_q    <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= 32'h0000_0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef DCACHE_PERF_CNT_EN
      perf_hit_q  <= 32'd0;
      perf_miss_q <= 32'd0;
`endif
    end else begin
      cpu_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            replay_q <= 1'b0;
            if (hit_s) begin
              if (cpu_we) begin
                dirty_q[idx_s] <= 1'b1;
              end else begin
                cpu_rdata_q <= old_word_s;
              end
              cpu_ready_q <= 1'b1;
              state_q     <= S_RESP;
`ifdef DCACHE_PERF_CNT_EN
              if (!replay_q) begin
                perf_hit_q <= perf_hit_q + 32'd1;
              end
`endif
            end else begin
`ifdef DCACHE_PERF_CNT_EN
              perf_miss_q <= perf_miss_q + 32'd1;
`endif
              mem_req_q <= 1'b1;
              if (vic_dirty_s) begin
                // Victim must reach memory before its slot is refilled.
                mem_we_q    <= 1'b1;
                mem_addr_q  <= {vic_tag_s, idx_s};
                mem_wdata_q <= line_s;
                state_q     <= S_WB;
              end else begin
                mem_addr_q <= line_addr_s;
                state_q    <= S_RREQ;
              end
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        S_WB: begin
          dirty_q[idx_s] <= 1'b0;
          mem_req_q      <= 1'b1;
          mem_addr_q     <= line_addr_s;
          state_q        <= S_RREQ;
        end
        S_RREQ: begin
          state_q <= S_RWAIT;
        end
        S_RWAIT: begin
          if (mem_ready) begin
            valid_q[idx_s] <= 1'b1;
            dirty_q[idx_s] <= 1'b0;
            replay_q       <= 1'b1;
            state_q        <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef DCACHE_PERF_CNT_EN
  assign perf_hit_cnt  = perf_hit_q;
  assign perf_miss_cnt = perf_miss_q;
`endif

endmodule

// File: doc/dcache_direct_wb.md
Name: dcache_direct_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and the 256-bit line-wide main memory.
- Serves 32-bit word accesses from a register-based line array.
- On a miss it writes back a dirty victim, refills the line from main memory, then replays the access.
- Blocking: one outstanding CPU request at a time.

Parameters:
- MEM_ADDR_WIDTH, 12, main-memory line-address width (line = 32 bytes).
- LINE_WIDTH, 256, line width in bits; fixed at 8 x 32-bit words.
- INDEX_BITS, 6, number of cache lines = 2^INDEX_BITS; tag width = MEM_ADDR_WIDTH-INDEX_BITS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  access request; held high until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address; [4:2] word select, [MEM_ADDR_WIDTH+4:5] line address, upper bits ignored.
- cpu_be  in  4  store byte enables; ignored on loads.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request, one cycle per transfer.
- mem_we  out  1  memory write.
- mem_addr  out  MEM_ADDR_WIDTH  line address.
- mem_wdata  out  LINE_WIDTH  write-back line.
- mem_rdata  in  LINE_WIDTH  refill line.
- mem_ready  in  1  read-data-valid pulse; memory gives no ready on writes.

Behaviour:
- Reset values: all valid/dirty bits 0, state IDLE, cpu_ready 0, cpu_rdata 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0. Tag/data arrays are not reset.
- rst_n must be held low for at least 2 clk edges so that in-flight memory reads drain.
- All outputs are registered or decoded from the state register only; no combinational CPU-to-memory paths.
- State IDLE: on cpu_req, compare the tag at the index.
  - Hit load: latch the selected word into cpu_rdata, go to RESP.
  - Hit store: merge cpu_wdata bytes per cpu_be into the word, set dirty, go to RESP.
  - Miss with victim valid and dirty: go to WB.
  - Other miss: go to RREQ.
- RESP: cpu_ready=1 for exactly this cycle, then go to IDLE unconditionally. A still-high cpu_req is not re-sampled in RESP.
- WB (1 cycle): mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim line. Clear dirty, go to RREQ.
- RREQ (1 cycle): mem_req=1, mem_we=0, mem_addr=requested line address. Go to RWAIT.
- RWAIT: hold mem_req=0. On mem_ready, install mem_rdata with the tag, set valid=1 and dirty=0, go to IDLE. IDLE then replays the held request as a hit.
- mem_ready is ignored in every state except RWAIT.
- Latency, counted in cycles from the accepting edge to the cycle where cpu_ready is high:
  - hit: 1
  - clean miss: 5
  - dirty miss: 6
- Memory read latency is taken from mem_ready, not hard-coded; longer latency stretches RWAIT.
- A store miss allocates the line, then performs the store on replay; the line ends dirty.
- A request to the same index with a different tag evicts the resident line (direct-mapped conflict).
- cpu_rdata holds its value until the next load hit.
- Asynchronous reset mid-miss: return to IDLE immediately and invalidate all lines; a partially issued refill is discarded.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- Defined: adds output ports perf_hit_cnt[31:0] and perf_miss_cnt[31:0], both reset to 0.
  - perf_hit_cnt increments on each IDLE hit, excluding replays after a refill.
  - perf_miss_cnt increments on each IDLE miss.
  - Both wrap modulo 2^32.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- After reset, load at 0x0000_0040 with memory line 2 word0=0xDEADBEEF -> one RREQ to mem_addr 0x002, no WB, cpu_ready 5 cycles after acceptance, cpu_rdata=0xDEADBEEF.
- Repeat the load of 0x40 -> mem_req stays 0, cpu_ready after 1 cycle, same data.
- Store 0x11223344 with be=4'b0101 to 0x44 (line contains 0xAABBCCDD) -> a following load of 0x44 returns 0xAA22CC44, line dirty, no memory write.
- Load 0x0000_0840 (same index 2, tag 1) -> WB with mem_addr 0x002 and the modified line, then RREQ to 0x042, cpu_ready 6 cycles after acceptance; reloading 0x44 afterwards refills from memory and returns 0xAA22CC44.
- Stretch mem_ready to 10 cycles after mem_req -> cache stays in RWAIT, cpu_ready not asserted early; a spurious mem_ready while in IDLE has no effect.
- Assert rst_n low in RWAIT -> outputs return to reset values at once; a subsequent load to the same address misses again. With DCACHE_PERF_CNT_EN defined, hit/miss counts match the scenario totals.
